// File: rtl/rx_pkg.sv
// Shared types and defaults for the serial receive path.
//   rx_state_t         receive control FSM states
//   SYNC_BYTE_DEFAULT  expected first assembled byte (LSB-first SYNC)
//   MAX_BYTES_DEFAULT  data bytes allowed per packet after SYNC
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RCV_SYNC,
    CHK_SYNC,
    RCV_BYTE,
    STORE,
    ERR_DRAIN,
    EOP_WAIT
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;
  localparam int         MAX_BYTES_DEFAULT = 64;

endpackage

// File: rtl/rx_rcu_if.sv
// Signal bundle between the receive control unit and its neighbours
// (edge detector, bit/byte timer, RX FIFO, status).
//   slave  : the RCU's view (line/timer strobes in, control/status out)
//   master : the environment's view
interface rx_rcu_if;
  logic       d_edge;         // one-cycle pulse on any line transition
  logic       eop;            // line in SE0
  logic       shift_enable;   // bit-sample strobe from timer
  logic       byte_received;  // 8 bits shifted in
  logic [7:0] rcv_data;       // shift register, valid cycle after byte_received
  logic       rcving;         // reception in progress (timer enable)
  logic       w_enable;       // FIFO write strobe
  logic       r_error;        // sticky receive error
  logic [6:0] byte_count;     // data bytes written this packet

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data,
    output rcving, w_enable, r_error, byte_count
  );

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data,
    input  rcving, w_enable, r_error, byte_count
  );
endinterface

// File: rtl/rx_rcu.sv
// Receive control unit: validates SYNC, strobes one FIFO write per data
// byte, detects EOP and flags framing errors (bad sync, early EOP,
// partial byte at EOP, overlong packet).
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : rx_rcu_if.slave (timer/edge/eop in; rcving, w_enable,
//                r_error, byte_count out)
// Outputs are Moore, decoded from the registered state.
module rx_rcu
  import rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic     clk,
  input  logic     n_rst,
  rx_rcu_if.slave  bus
);

  rx_state_t  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] byte_count_q, byte_count_d;
  logic       r_error_q, r_error_d;

  logic       eop_bit;
  logic [6:0] byte_count_inc;

  // EOP is only acted on at a bit-sample point so a glitchy SE0 between
  // samples does not end the packet.
  assign eop_bit        = bus.eop & bus.shift_enable;
  assign byte_count_inc = (byte_count_q == 7'h7f) ? 7'h7f : byte_count_q + 7'd1;

  always_comb begin
    state_d      = state_q;
    r_error_d    = r_error_q;
    byte_count_d = byte_count_q;
    bit_cnt_d    = bit_cnt_q;

    if (bus.byte_received)     bit_cnt_d = 3'd0;
    else if (bus.shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (bus.d_edge) begin
          state_d      = RCV_SYNC;
          r_error_d    = 1'b0;
          byte_count_d = 7'd0;
          bit_cnt_d    = 3'd0;
        end
      end
      RCV_SYNC: begin
        if (eop_bit) begin
          state_d   = EOP_WAIT;
          r_error_d = 1'b1;
        end else if (bus.byte_received) begin
          state_d = CHK_SYNC;
        end
      end
      CHK_SYNC: begin
        if (bus.rcv_data == SYNC_BYTE) begin
          state_d = RCV_BYTE;
        end else begin
          state_d   = ERR_DRAIN;
          r_error_d = 1'b1;
        end
      end
      RCV_BYTE: begin
        // EOP wins over a coincident byte_received: the packet is over.
        if (eop_bit) begin
          state_d = EOP_WAIT;
          if (bit_cnt_q != 3'd0) r_error_d = 1'b1;
        end else if (bus.byte_received) begin
          state_d = STORE;
        end
      end
      STORE: begin
        byte_count_d = byte_count_inc;
        // The overflowing byte is still written; only later bytes are dropped.
        if (int'(byte_count_inc) > MAX_BYTES) begin
          state_d   = ERR_DRAIN;
          r_error_d = 1'b1;
        end else begin
          state_d = RCV_BYTE;
        end
      end
      ERR_DRAIN: begin
        if (eop_bit) state_d = EOP_WAIT;
      end
      EOP_WAIT: begin
        if (bus.d_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      byte_count_q <= 7'd0;
      r_error_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_count_q <= byte_count_d;
      r_error_q    <= r_error_d;
    end
  end

  assign bus.rcving     = (state_q == RCV_SYNC) || (state_q == CHK_SYNC) ||
                          (state_q == RCV_BYTE) || (state_q == STORE) ||
                          (state_q == ERR_DRAIN);
  assign bus.w_enable   = (state_q == STORE);
  assign bus.r_error    = r_error_q;
  assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_rx_rcu.sv
// Directed bench for rx_rcu. Two instances share one stimulus stream:
// dut_a uses the default MAX_BYTES, dut_b uses MAX_BYTES=4.
module tb_rx_rcu;
  import rx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0, eop = 1'b0, se = 1'b0, br = 1'b0;
  logic [7:0] rd = 8'h00;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic err_chk_a, err_chk_b;
  logic [7:0] wq_a[$];
  logic [7:0] wq_b[$];

  always #5 clk = ~clk;

  rx_rcu_if ifa();
  rx_rcu_if ifb();

  assign ifa.d_edge = d_edge;  assign ifb.d_edge = d_edge;
  assign ifa.eop = eop;        assign ifb.eop = eop;
  assign ifa.shift_enable = se;  assign ifb.shift_enable = se;
  assign ifa.byte_received = br; assign ifb.byte_received = br;
  assign ifa.rcv_data = rd;    assign ifb.rcv_data = rd;

  rx_rcu dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
  rx_rcu #(.SYNC_BYTE(8'h80), .MAX_BYTES(4)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

  // capture FIFO writes mid-cycle
  always @(negedge clk) begin
    if (ifa.w_enable) wq_a.push_back(ifa.rcv_data);
    if (ifb.w_enable) wq_b.push_back(ifb.rcv_data);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; d_edge = 0; eop = 0; se = 0; br = 0; rd = 8'h00;
    cyc(); cyc();
    n_rst = 1'b1;
    cyc();
    wq_a.delete(); wq_b.delete();
  endtask

  task automatic start_pkt();
    d_edge = 1'b1; cyc(); d_edge = 1'b0; cyc();
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) begin
      se = 1'b1; cyc(); se = 1'b0; cyc(); cyc();
    end
  endtask

  // 8 bit samples, then byte_received with the assembled byte; records
  // r_error as seen in the cycle right after byte_received.
  task automatic send_byte(input logic [7:0] b);
    shifts(8);
    br = 1'b1; rd = b; cyc(); br = 1'b0;
    @(negedge clk); err_chk_a = ifa.r_error; err_chk_b = ifb.r_error;
    cyc(); cyc();
  endtask

  task automatic end_eop();
    eop = 1'b1; se = 1'b1; cyc(); se = 1'b0; cyc(); cyc();
  endtask

  task automatic line_idle();
    eop = 1'b0; d_edge = 1'b1; cyc(); d_edge = 1'b0; cyc();
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++; if ({ifa.rcving, ifa.w_enable, ifa.r_error, ifa.byte_count} !== 10'd0)
      $display("FAIL reset_a got %b exp 0", {ifa.rcving, ifa.w_enable, ifa.r_error, ifa.byte_count}); else pass_cnt++;
    tot_cnt++; if ({ifb.rcving, ifb.w_enable, ifb.r_error, ifb.byte_count} !== 10'd0)
      $display("FAIL reset_b got %b exp 0", {ifb.rcving, ifb.w_enable, ifb.r_error, ifb.byte_count}); else pass_cnt++;
  endtask

  task automatic test_good_packet();
    do_reset();
    start_pkt();
    tot_cnt++; if (ifa.rcving !== 1'b1) $display("FAIL good_rcving got %b exp 1", ifa.rcving); else pass_cnt++;
    send_byte(8'h80); send_byte(8'hA5); send_byte(8'h3C);
    end_eop();
    tot_cnt++; if (wq_a.size() !== 2) $display("FAIL good_nwr got %0d exp 2", wq_a.size()); else pass_cnt++;
    if (wq_a.size() == 2) begin
      tot_cnt++; if (wq_a[0] !== 8'hA5 || wq_a[1] !== 8'h3C)
        $display("FAIL good_data got %h %h exp a5 3c", wq_a[0], wq_a[1]); else pass_cnt++;
    end
    tot_cnt++; if (ifa.byte_count !== 7'd2) $display("FAIL good_bc got %0d exp 2", ifa.byte_count); else pass_cnt++;
    tot_cnt++; if (ifa.r_error !== 1'b0) $display("FAIL good_err got %b exp 0", ifa.r_error); else pass_cnt++;
    tot_cnt++; if (ifa.rcving !== 1'b0) $display("FAIL good_eop_rcving got %b exp 0", ifa.rcving); else pass_cnt++;
    line_idle();
    tot_cnt++; if (dut_a.state_q !== IDLE) $display("FAIL good_idle got %0d exp %0d", dut_a.state_q, IDLE); else pass_cnt++;
    tot_cnt++; if (ifa.byte_count !== 7'd2) $display("FAIL good_bc_hold got %0d exp 2", ifa.byte_count); else pass_cnt++;
  endtask

  task automatic test_bad_sync();
    do_reset();
    start_pkt();
    send_byte(8'h81);
    tot_cnt++; if (err_chk_a !== 1'b0) $display("FAIL badsync_err_chk got %b exp 0", err_chk_a); else pass_cnt++;
    tot_cnt++; if (ifa.r_error !== 1'b1) $display("FAIL badsync_err got %b exp 1", ifa.r_error); else pass_cnt++;
    send_byte(8'h11); send_byte(8'h22);
    end_eop();
    tot_cnt++; if (wq_a.size() !== 0) $display("FAIL badsync_nwr got %0d exp 0", wq_a.size()); else pass_cnt++;
    line_idle();
    tot_cnt++; if (ifa.r_error !== 1'b1 || ifa.rcving !== 1'b0)
      $display("FAIL badsync_idle_err got %b%b exp 10", ifa.r_error, ifa.rcving); else pass_cnt++;
    start_pkt();
    tot_cnt++; if (ifa.r_error !== 1'b0) $display("FAIL badsync_clear got %b exp 0", ifa.r_error); else pass_cnt++;
  endtask

  task automatic test_partial_byte();
    do_reset();
    start_pkt();
    send_byte(8'h80); send_byte(8'hA5);
    shifts(3);
    end_eop();
    tot_cnt++; if (wq_a.size() !== 1) $display("FAIL partial_nwr got %0d exp 1", wq_a.size()); else pass_cnt++;
    tot_cnt++; if (ifa.r_error !== 1'b1) $display("FAIL partial_err got %b exp 1", ifa.r_error); else pass_cnt++;
    tot_cnt++; if (ifa.byte_count !== 7'd1) $display("FAIL partial_bc got %0d exp 1", ifa.byte_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    start_pkt();
    send_byte(8'h80);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    tot_cnt++; if (ifb.r_error !== 1'b0) $display("FAIL ovf_err4 got %b exp 0", ifb.r_error); else pass_cnt++;
    send_byte(8'h05);
    tot_cnt++; if (err_chk_b !== 1'b0) $display("FAIL ovf_err_store got %b exp 0", err_chk_b); else pass_cnt++;
    tot_cnt++; if (ifb.r_error !== 1'b1) $display("FAIL ovf_err got %b exp 1", ifb.r_error); else pass_cnt++;
    send_byte(8'h06);
    end_eop();
    tot_cnt++; if (wq_b.size() !== 5) $display("FAIL ovf_nwr got %0d exp 5", wq_b.size()); else pass_cnt++;
    if (wq_b.size() == 5) begin
      tot_cnt++; if (wq_b[4] !== 8'h05) $display("FAIL ovf_last got %h exp 05", wq_b[4]); else pass_cnt++;
    end
    tot_cnt++; if (ifb.byte_count !== 7'd5) $display("FAIL ovf_bc got %0d exp 5", ifb.byte_count); else pass_cnt++;
    tot_cnt++; if (wq_a.size() !== 6 || ifa.byte_count !== 7'd6 || ifa.r_error !== 1'b0)
      $display("FAIL ovf_big got nwr=%0d bc=%0d err=%b exp 6 6 0", wq_a.size(), ifa.byte_count, ifa.r_error); else pass_cnt++;
  endtask

  task automatic test_early_eop();
    do_reset();
    start_pkt();
    shifts(3);
    end_eop();
    tot_cnt++; if (ifa.r_error !== 1'b1 || ifa.rcving !== 1'b0)
      $display("FAIL early_eop got err=%b rcving=%b exp 1 0", ifa.r_error, ifa.rcving); else pass_cnt++;
    // eop at a bit sample coinciding with byte_received: EOP wins
    do_reset();
    start_pkt();
    send_byte(8'h80); send_byte(8'hA5);
    shifts(8);
    br = 1'b1; se = 1'b1; eop = 1'b1; rd = 8'hFF; cyc();
    br = 1'b0; se = 1'b0; cyc(); cyc();
    tot_cnt++; if (wq_a.size() !== 1) $display("FAIL simul_nwr got %0d exp 1", wq_a.size()); else pass_cnt++;
    tot_cnt++; if (dut_a.state_q !== EOP_WAIT || ifa.r_error !== 1'b0 || ifa.byte_count !== 7'd1)
      $display("FAIL simul_state got st=%0d err=%b bc=%0d exp %0d 0 1", dut_a.state_q, ifa.r_error, ifa.byte_count, EOP_WAIT);
    else pass_cnt++;
    line_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_pkt();
    send_byte(8'h80); send_byte(8'h11); send_byte(8'h22);
    n_rst = 1'b0; #1;
    tot_cnt++; if ({ifa.rcving, ifa.w_enable, ifa.r_error, ifa.byte_count} !== 10'd0)
      $display("FAIL midrst_async got %b exp 0", {ifa.rcving, ifa.w_enable, ifa.r_error, ifa.byte_count}); else pass_cnt++;
    cyc(); n_rst = 1'b1; cyc();
    wq_a.delete();
    start_pkt();
    send_byte(8'h80); send_byte(8'h5A);
    end_eop();
    tot_cnt++; if (wq_a.size() !== 1 || ifa.byte_count !== 7'd1 || ifa.r_error !== 1'b0)
      $display("FAIL midrst_pkt got nwr=%0d bc=%0d err=%b exp 1 1 0", wq_a.size(), ifa.byte_count, ifa.r_error); else pass_cnt++;
    if (wq_a.size() == 1) begin
      tot_cnt++; if (wq_a[0] !== 8'h5A) $display("FAIL midrst_data got %h exp 5a", wq_a[0]); else pass_cnt++;
    end
    line_idle();
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_sync();
    test_partial_byte();
    test_overflow();
    test_early_eop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/rx_rcu.md
Name: rx_rcu

Overview:
Receive control unit for the USB-style serial receiver. Sits directly upstream of the bit/byte timer: it drives that timer's rcving enable and consumes its shift_enable and byte_received strobes. It validates the SYNC byte, pulses a FIFO write per data byte, detects EOP, and flags framing errors (bad sync, partial byte at EOP, overlong packet, early EOP).

Parameters:
SYNC_BYTE, 8'h80, required value of first assembled byte (LSB-first shift of USB SYNC pattern)
MAX_BYTES, 64, maximum data bytes per packet after SYNC; exceeding it is an error

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_edge  input  1  one-cycle pulse on any line transition (from edge detector)
eop  input  1  line currently in SE0 (end-of-packet) condition
shift_enable  input  1  one-cycle bit-sample strobe from timer
byte_received  input  1  one-cycle pulse from timer when 8 bits are shifted in
rcv_data  input  8  current shift-register contents, valid in the cycle after byte_received
rcving  output  1  packet reception in progress; enables timer counters
w_enable  output  1  one-cycle write strobe to RX FIFO; rcv_data is the write data
r_error  output  1  sticky receive error flag
byte_count  output  7  data bytes written in current packet (excludes SYNC)

Behaviour:
- Reset (n_rst=0, async): state IDLE; rcving=0, w_enable=0, r_error=0, byte_count=0, internal bit_cnt=0.
- All outputs are Moore, decoded from registered state; r_error and byte_count are registers.
- bit_cnt (3-bit, internal): cleared on byte_received or on entry to RCV_SYNC; increments on shift_enable otherwise; wraps 7->0.
- States and transitions (evaluated each clk):
  - IDLE: rcving=0. d_edge -> RCV_SYNC; r_error cleared, byte_count cleared on that transition.
  - RCV_SYNC: rcving=1. eop&&shift_enable -> EOP_WAIT with r_error set (early EOP). Else byte_received -> CHK_SYNC.
  - CHK_SYNC: rcving=1, one cycle. rcv_data==SYNC_BYTE -> RCV_BYTE; else -> ERR_DRAIN with r_error set.
  - RCV_BYTE: rcving=1. eop&&shift_enable: bit_cnt==0 -> EOP_WAIT (clean); bit_cnt!=0 -> EOP_WAIT with r_error set (partial byte). Else byte_received -> STORE. eop has priority over byte_received in the same cycle.
  - STORE: rcving=1, w_enable=1 for exactly this cycle; byte_count increments. If new byte_count > MAX_BYTES -> ERR_DRAIN with r_error set (the write still occurs). Else -> RCV_BYTE.
  - ERR_DRAIN: rcving=1, no writes. eop&&shift_enable -> EOP_WAIT.
  - EOP_WAIT: rcving=0. d_edge (SE0->J return) -> IDLE. r_error unchanged.
- r_error is sticky: stays high through EOP_WAIT and IDLE until the d_edge that starts the next packet.
- byte_count saturates at 127; held after packet end until next packet start.
- w_enable never asserts outside STORE; at most one pulse per byte_received.
- d_edge in any state other than IDLE/EOP_WAIT is ignored by the FSM.
- Reset mid-packet returns to IDLE immediately; no w_enable after reset deasserts until a full SYNC is accepted.

Decomposition:
- Shared package rx_pkg: state enum type rx_state_t (IDLE, RCV_SYNC, CHK_SYNC, RCV_BYTE, STORE, ERR_DRAIN, EOP_WAIT), constant SYNC_BYTE_DEFAULT=8'h80, constant MAX_BYTES_DEFAULT=64.
- No sub-module: single FSM plus bit_cnt and byte_count registers; the timer remains a separate instance in the receiver top.

Test Plan:
- Good packet: d_edge, SYNC 8'h80, data 8'hA5, 8'h3C, EOP on bit boundary -> two w_enable pulses with rcv_data A5 then 3C, byte_count=2, r_error=0, rcving=0 after EOP, IDLE after d_edge.
- Bad sync: first byte 8'h81, then 2 bytes, EOP -> no w_enable, r_error=1 from the cycle after CHK_SYNC, held through IDLE until next d_edge.
- Partial byte: SYNC, one data byte, 3 shift_enables, EOP -> one w_enable, r_error=1, byte_count=1.
- Overflow with MAX_BYTES=4: SYNC + 5 bytes -> 5 w_enable pulses, r_error set in cycle after 5th STORE, no further writes until EOP; byte_count=5.
- Early EOP during SYNC and simultaneous eop&&shift_enable with byte_received in RCV_BYTE -> EOP path taken, r_error=1 for early EOP, no extra w_enable.
- Reset mid-packet after 2 data bytes: n_rst low 1 cycle -> all outputs 0 immediately; next valid packet received cleanly with byte_count starting at 0.
